// File: rtl/mem_d_arbiter.sv
// Arbiter sharing the data port of dual_port_mem between the core data interface (m0)
// and a secondary bus master (m1), with round-robin, bounded m1 burst lock and read routing.
module mem_d_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int MASK_W     = 4,
    parameter int RD_LATENCY = 1,
    parameter int MAX_BURST  = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [MASK_W-1:0] m0_wmask,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [MASK_W-1:0] m1_wmask,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    input  logic              m1_lock,

    output logic              mem_we,
    output logic [MASK_W-1:0] mem_wmask,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,

    output logic              dbg_last_owner,
    output logic [7:0]        dbg_burst_cnt
);

    // Handshake: a master raises mN_req and holds its fields stable; the cycle in which
    // mN_gnt is high is the transfer. mN_rvalid is a single-cycle pulse with no back-pressure.

    localparam logic       OWNER_M0  = 1'b0;
    localparam logic       OWNER_M1  = 1'b1;
    localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

    logic                  last_owner;
    logic [7:0]            burst_cnt;
    logic                  lock_active;
    logic                  pick_m0;
    logic                  pick_m1;
    logic                  xfer;
    logic [RD_LATENCY-1:0] trk_valid;
    logic [RD_LATENCY-1:0] trk_owner;

    assign lock_active = m1_lock && (last_owner == OWNER_M1) && (burst_cnt < BURST_LIM);

    // Grants are held low while reset is asserted, even if requests are present.
    always_comb begin
        pick_m0 = 1'b0;
        pick_m1 = 1'b0;
        if (reset) begin
            if (m0_req && m1_req) begin
                if (lock_active || (last_owner == OWNER_M0)) begin
                    pick_m1 = 1'b1;
                end else begin
                    pick_m0 = 1'b1;
                end
            end else if (m0_req) begin
                pick_m0 = 1'b1;
            end else if (m1_req) begin
                pick_m1 = 1'b1;
            end
        end
    end

    assign m0_gnt = pick_m0;
    assign m1_gnt = pick_m1;
    assign xfer   = pick_m0 | pick_m1;

    assign mem_we    = pick_m1 ? m1_we    : (pick_m0 ? m0_we    : 1'b0);
    assign mem_wmask = pick_m1 ? m1_wmask : (pick_m0 ? m0_wmask : '0);
    assign mem_a     = pick_m1 ? m1_addr  : m0_addr;
    assign mem_wd    = pick_m1 ? m1_wdata : m0_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner <= OWNER_M1;
            burst_cnt  <= 8'd0;
        end else begin
            if (pick_m0) begin
                last_owner <= OWNER_M0;
            end else if (pick_m1) begin
                last_owner <= OWNER_M1;
            end
            if (pick_m0 || !m1_lock) begin
                burst_cnt <= 8'd0;
            end else if (pick_m1 && (burst_cnt < BURST_LIM)) begin
                burst_cnt <= burst_cnt + 8'd1;
            end
        end
    end

    // One entry per transfer; the tail lines up with the memory's read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trk_valid <= '0;
            trk_owner <= '0;
        end else begin
            trk_valid[0] <= xfer && !mem_we;
            trk_owner[0] <= pick_m1;
            for (int i = 1; i < RD_LATENCY; i++) begin
                trk_valid[i] <= trk_valid[i-1];
                trk_owner[i] <= trk_owner[i-1];
            end
        end
    end

    assign m0_rvalid = trk_valid[RD_LATENCY-1] && (trk_owner[RD_LATENCY-1] == OWNER_M0);
    assign m1_rvalid = trk_valid[RD_LATENCY-1] && (trk_owner[RD_LATENCY-1] == OWNER_M1);
    assign m0_rdata  = mem_rd;
    assign m1_rdata  = mem_rd;

    assign dbg_last_owner = last_owner;
    assign dbg_burst_cnt  = burst_cnt;

endmodule

// File: tb/tb_mem_d_arbiter.sv
// Directed bench for mem_d_arbiter: two instances (read latency 1 and 3) share the
// master-side stimulus; each has its own behavioural memory model.
module tb_mem_d_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
    logic [3:0]  m0_wmask, m1_wmask;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

    logic        s_m0_gnt, s_m0_rvalid, s_m1_gnt, s_m1_rvalid, s_mem_we, s_last_owner;
    logic [31:0] s_m0_rdata, s_m1_rdata, s_mem_a, s_mem_wd, s_mem_rd;
    logic [3:0]  s_mem_wmask;
    logic [7:0]  s_burst_cnt;

    logic        l_m0_gnt, l_m0_rvalid, l_m1_gnt, l_m1_rvalid, l_mem_we, l_last_owner;
    logic [31:0] l_m0_rdata, l_m1_rdata, l_mem_a, l_mem_wd, l_mem_rd;
    logic [3:0]  l_mem_wmask;
    logic [7:0]  l_burst_cnt;

    logic        load_en;
    logic [31:0] load_addr, load_val;

    int n_cmp = 0;
    int n_bad = 0;

    mem_d_arbiter #(.RD_LATENCY(1), .MAX_BURST(8)) dut_s (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_wmask(m0_wmask), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(s_m0_gnt), .m0_rvalid(s_m0_rvalid), .m0_rdata(s_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_wmask(m1_wmask), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(s_m1_gnt), .m1_rvalid(s_m1_rvalid), .m1_rdata(s_m1_rdata),
        .m1_lock(m1_lock),
        .mem_we(s_mem_we), .mem_wmask(s_mem_wmask), .mem_a(s_mem_a), .mem_wd(s_mem_wd),
        .mem_rd(s_mem_rd), .dbg_last_owner(s_last_owner), .dbg_burst_cnt(s_burst_cnt)
    );

    mem_d_arbiter #(.RD_LATENCY(3), .MAX_BURST(8)) dut_l (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_wmask(m0_wmask), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(l_m0_gnt), .m0_rvalid(l_m0_rvalid), .m0_rdata(l_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_wmask(m1_wmask), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(l_m1_gnt), .m1_rvalid(l_m1_rvalid), .m1_rdata(l_m1_rdata),
        .m1_lock(m1_lock),
        .mem_we(l_mem_we), .mem_wmask(l_mem_wmask), .mem_a(l_mem_a), .mem_wd(l_mem_wd),
        .mem_rd(l_mem_rd), .dbg_last_owner(l_last_owner), .dbg_burst_cnt(l_burst_cnt)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    // Behavioural memories: byte-masked writes, read data after 1 or 3 cycles.
    logic [31:0] mem_s [0:255];
    logic [31:0] mem_l [0:255];
    logic [31:0] pipe_s;
    logic [31:0] pipe_l [0:2];

    always @(posedge clk) begin
        if (load_en) begin
            mem_s[load_addr[9:2]] <= load_val;
            mem_l[load_addr[9:2]] <= load_val;
        end
        if (s_mem_we) begin
            for (int b = 0; b < 4; b++)
                if (s_mem_wmask[b]) mem_s[s_mem_a[9:2]][8*b +: 8] <= s_mem_wd[8*b +: 8];
        end
        if (l_mem_we) begin
            for (int b = 0; b < 4; b++)
                if (l_mem_wmask[b]) mem_l[l_mem_a[9:2]][8*b +: 8] <= l_mem_wd[8*b +: 8];
        end
        pipe_s    <= mem_s[s_mem_a[9:2]];
        pipe_l[0] <= mem_l[l_mem_a[9:2]];
        pipe_l[1] <= pipe_l[0];
        pipe_l[2] <= pipe_l[1];
    end

    assign s_mem_rd = pipe_s;
    assign l_mem_rd = pipe_l[2];

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] v);
        load_en   = 1'b1;
        load_addr = a;
        load_val  = v;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic drive_m0(input logic req, input logic we, input logic [31:0] a);
        m0_req  = req;
        m0_we   = we;
        m0_addr = a;
    endtask

    task automatic drive_m1(input logic req, input logic we, input logic [31:0] a);
        m1_req  = req;
        m1_we   = we;
        m1_addr = a;
    endtask

    // Scoreboard check
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        load_en = 1'b0; load_addr = '0; load_val = '0;
        m0_req = 0; m0_we = 0; m0_wmask = 4'hF; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_wmask = 4'hF; m1_addr = '0; m1_wdata = '0;
        m1_lock = 0;

        load_word(32'h10, 32'hDEADBEEF);
        load_word(32'h20, 32'hAABBCCDD);
        load_word(32'h50, 32'h11111111);
        load_word(32'h54, 32'h22222222);
        load_word(32'h58, 32'h33333333);

        // Requests during reset must not be granted.
        drive_m0(1, 0, 32'h10);
        drive_m1(1, 0, 32'h14);
        mid();
        chk("rst_m0_gnt", s_m0_gnt, 0);
        chk("rst_m1_gnt", s_m1_gnt, 0);
        chk("rst_mem_we", s_mem_we, 0);
        chk("rst_mem_wmask", s_mem_wmask, 0);
        chk("rst_m0_rvalid", s_m0_rvalid, 0);
        chk("rst_m1_rvalid", l_m1_rvalid, 0);
        chk("rst_last_owner", s_last_owner, 1);
        chk("rst_burst_cnt", s_burst_cnt, 0);

        // Single m0 read, latency 1.
        tick();
        reset = 1'b1;
        drive_m1(0, 0, 32'h0);
        drive_m0(1, 0, 32'h10);
        mid();
        chk("rd1_m0_gnt", s_m0_gnt, 1);
        chk("rd1_m1_gnt", s_m1_gnt, 0);
        chk("rd1_mem_a", s_mem_a, 32'h10);
        tick();
        drive_m0(0, 0, 32'h0);
        mid();
        chk("rd1_m0_rvalid", s_m0_rvalid, 1);
        chk("rd1_m0_rdata", s_m0_rdata, 32'hDEADBEEF);
        chk("rd1_m1_rvalid", s_m1_rvalid, 0);
        tick(); tick(); tick();

        // Round-robin under continuous contention, starting from reset.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        drive_m0(1, 0, 32'h100);
        drive_m1(1, 0, 32'h200);
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("rr_m0_gnt", s_m0_gnt, (i % 2 == 0) ? 1 : 0);
            chk("rr_m1_gnt", s_m1_gnt, (i % 2 == 1) ? 1 : 0);
            chk("rr_mem_a", s_mem_a, (i % 2 == 0) ? 32'h100 : 32'h200);
            tick();
        end
        drive_m0(0, 0, 32'h0);
        drive_m1(0, 0, 32'h0);
        tick(); tick(); tick(); tick();

        // Masked m1 write, then m0 read-back.
        drive_m1(1, 1, 32'h20);
        m1_wdata = 32'h12345678;
        m1_wmask = 4'b0011;
        mid();
        chk("wr_m1_gnt", s_m1_gnt, 1);
        chk("wr_mem_we", s_mem_we, 1);
        chk("wr_mem_wmask", s_mem_wmask, 4'b0011);
        chk("wr_mem_wd", s_mem_wd, 32'h12345678);
        chk("wr_mem_a", s_mem_a, 32'h20);
        tick();
        drive_m1(0, 0, 32'h0);
        m1_wmask = 4'hF;
        drive_m0(1, 0, 32'h20);
        mid();
        chk("wrrd_m0_gnt", s_m0_gnt, 1);
        chk("wrrd_mem_we", s_mem_we, 0);
        tick();
        drive_m0(0, 0, 32'h0);
        mid();
        chk("wrrd_m0_rvalid", s_m0_rvalid, 1);
        chk("wrrd_m0_rdata", s_m0_rdata, 32'hAABB5678);
        tick(); tick(); tick();

        // Burst lock: last owner is m0, so m1 wins once by alternation, then 7 locked grants.
        drive_m0(1, 0, 32'h30);
        drive_m1(1, 0, 32'h40);
        m1_lock = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mid();
            chk("lock_m1_gnt", s_m1_gnt, 1);
            chk("lock_m0_gnt", s_m0_gnt, 0);
            tick();
        end
        mid();
        chk("lock_cnt_sat", s_burst_cnt, 8);
        chk("lock_release_m0_gnt", s_m0_gnt, 1);
        chk("lock_release_m1_gnt", s_m1_gnt, 0);
        tick();
        mid();
        chk("lock_cnt_clr", s_burst_cnt, 0);
        chk("lock_last_owner", s_last_owner, 0);
        chk("lock_alt_m1_gnt", s_m1_gnt, 1);
        tick();
        drive_m1(0, 0, 32'h0);
        mid();
        chk("lock_cnt_one", s_burst_cnt, 1);
        chk("lock_idle_m0_gnt", s_m0_gnt, 1);
        tick();
        drive_m0(0, 0, 32'h0);
        mid();
        chk("lock_cnt_m0clr", s_burst_cnt, 0);
        m1_lock = 1'b0;
        tick(); tick(); tick(); tick();

        // Interleaved reads with latency 3.
        drive_m0(1, 0, 32'h50);
        mid();
        chk("il_m0_gnt", l_m0_gnt, 1);
        tick();
        drive_m0(0, 0, 32'h0);
        drive_m1(1, 0, 32'h54);
        mid();
        chk("il_m1_gnt", l_m1_gnt, 1);
        chk("il_early_m0_rvalid", l_m0_rvalid, 0);
        tick();
        drive_m1(0, 0, 32'h0);
        drive_m0(1, 0, 32'h58);
        mid();
        chk("il_early_m1_rvalid", l_m1_rvalid, 0);
        tick();
        drive_m0(0, 0, 32'h0);
        mid();
        chk("il_r0_m0_rvalid", l_m0_rvalid, 1);
        chk("il_r0_m1_rvalid", l_m1_rvalid, 0);
        chk("il_r0_rdata", l_m0_rdata, 32'h11111111);
        tick();
        mid();
        chk("il_r1_m1_rvalid", l_m1_rvalid, 1);
        chk("il_r1_m0_rvalid", l_m0_rvalid, 0);
        chk("il_r1_rdata", l_m1_rdata, 32'h22222222);
        tick();
        mid();
        chk("il_r2_m0_rvalid", l_m0_rvalid, 1);
        chk("il_r2_m1_rvalid", l_m1_rvalid, 0);
        chk("il_r2_rdata", l_m0_rdata, 32'h33333333);
        tick();
        mid();
        chk("il_done_m0_rvalid", l_m0_rvalid, 0);
        chk("il_done_m1_rvalid", l_m1_rvalid, 0);
        tick(); tick();

        // Reset with two reads in flight drops both responses.
        drive_m0(1, 0, 32'h50);
        tick();
        drive_m0(0, 0, 32'h0);
        drive_m1(1, 0, 32'h54);
        tick();
        drive_m1(0, 0, 32'h0);
        reset = 1'b0;
        mid();
        chk("fl_rst_m0_rvalid", l_m0_rvalid, 0);
        chk("fl_rst_m1_rvalid", l_m1_rvalid, 0);
        chk("fl_rst_last_owner", l_last_owner, 1);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mid();
            chk("fl_post_m0_rvalid", l_m0_rvalid, 0);
            chk("fl_post_m1_rvalid", l_m1_rvalid, 0);
            tick();
        end
        drive_m0(1, 0, 32'h60);
        drive_m1(1, 0, 32'h64);
        mid();
        chk("fl_first_m0_gnt", l_m0_gnt, 1);
        chk("fl_first_m1_gnt", l_m1_gnt, 0);
        tick();
        drive_m0(0, 0, 32'h0);
        drive_m1(0, 0, 32'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
